// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_PLD   = 3'd2,
    ST_CHK   = 3'd3,
    ST_RESP0 = 3'd4,
    ST_RESP1 = 3'd5
  } state_e;

  localparam logic [7:0] SOF_DEFAULT     = 8'hA5;

  localparam logic [7:0] STAT_ACK         = 8'h06;
  localparam logic [7:0] STAT_NAK_CHK     = 8'h15;
  localparam logic [7:0] STAT_NAK_LEN     = 8'h16;
  localparam logic [7:0] STAT_NAK_BUSY    = 8'h17;
  localparam logic [7:0] STAT_NAK_TIMEOUT = 8'h18;

  // States in which the parser pops the RX FIFO.
  function automatic logic consumes_rx(input state_e s);
    return (s == ST_IDLE) || (s == ST_LEN) || (s == ST_PLD) || (s == ST_CHK);
  endfunction

  // States covered by the inter-byte timeout.
  function automatic logic timed_state(input state_e s);
    return (s == ST_LEN) || (s == ST_PLD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Parses SOF/LEN/payload/checksum frames from the RX FIFO, holds the validated
// payload for the system and answers each frame with SOF + status on the TX FIFO.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned  MAX_PAYLOAD = 16,
  parameter int unsigned  TIMEOUT_CYC = 500_000,
  parameter logic [7:0]   SOF_BYTE    = SOF_DEFAULT,
  localparam int unsigned AW          = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_rd_en,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_full,
  input  logic [AW-1:0] i_pld_addr,
  output logic [7:0]    o_pld_data,
  output logic [7:0]    o_pld_len,
  output logic          o_pld_valid,
  input  logic          i_pld_ack,
  output logic          o_frame_err
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    status_q, status_d;
  logic          pld_valid_q, pld_valid_d;
  logic [7:0]    pld_len_q, pld_len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    buf_q [MAX_PAYLOAD];

  logic          rx_pop;
  logic          tx_fire;
  logic          timeout_hit;
  logic          len_bad;
  logic          last_pld;
  logic          buf_we;

  assign rx_pop      = consumes_rx(state_q) && i_rx_valid;
  assign tx_fire     = o_tx_valid && !i_tx_full;
  assign timeout_hit = timed_state(state_q) && !rx_pop && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign len_bad     = (i_rx_data == 8'd0) || (32'(i_rx_data) > MAX_PAYLOAD);
  assign last_pld    = (8'(idx_q + 8'd1) == len_q);
  assign buf_we      = (state_q == ST_PLD) && rx_pop && !busy_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_pop && (i_rx_data == SOF_BYTE)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (rx_pop)           state_d = len_bad ? ST_RESP0 : ST_PLD;
        else if (timeout_hit) state_d = ST_RESP0;
      end
      ST_PLD: begin
        if (rx_pop && last_pld) state_d = ST_CHK;
        else if (timeout_hit)   state_d = ST_RESP0;
      end
      ST_CHK: begin
        if (rx_pop || timeout_hit) state_d = ST_RESP0;
      end
      ST_RESP0: begin
        if (tx_fire) state_d = ST_RESP1;
      end
      ST_RESP1: begin
        if (tx_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO-facing outputs decoded from the current state
  always_comb begin
    o_rx_rd_en = rx_pop;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    unique case (state_q)
      ST_RESP0: begin
        o_tx_valid = 1'b1;
        o_tx_data  = SOF_BYTE;
      end
      ST_RESP1: begin
        o_tx_valid = 1'b1;
        o_tx_data  = status_q;
      end
      default: ;
    endcase
  end

  // Frame datapath: checksum, index, status and payload bookkeeping
  always_comb begin
    busy_d      = busy_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    len_d       = len_q;
    status_d    = status_q;
    pld_valid_d = pld_valid_q;
    pld_len_d   = pld_len_q;
    tmo_d       = tmo_q;

    if (i_pld_ack) pld_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_pop && (i_rx_data == SOF_BYTE)) begin
          busy_d = pld_valid_q;
          sum_d  = 8'd0;
          idx_d  = 8'd0;
        end
      end
      ST_LEN: begin
        if (rx_pop) begin
          sum_d = i_rx_data;
          if (len_bad) status_d = STAT_NAK_LEN;
          else         len_d    = i_rx_data;
        end
      end
      ST_PLD: begin
        if (rx_pop) begin
          sum_d = 8'(sum_q + i_rx_data);
          idx_d = 8'(idx_q + 8'd1);
        end
      end
      ST_CHK: begin
        if (rx_pop) begin
          if (i_rx_data != sum_q) begin
            status_d = STAT_NAK_CHK;
          end else if (busy_q) begin
            status_d = STAT_NAK_BUSY;
          end else begin
            status_d    = STAT_ACK;
            pld_valid_d = 1'b1;
            pld_len_d   = len_q;
          end
        end
      end
      default: ;
    endcase

    if (timeout_hit) status_d = STAT_NAK_TIMEOUT;

    // Counter restarts on every consumed byte and on every state change.
    if (!timed_state(state_q) || rx_pop || (state_d != state_q)) tmo_d = '0;
    else                                                          tmo_d = TW'(tmo_q + 1'b1);

    frame_err_d = (state_d == ST_RESP0) && (state_q != ST_RESP0) && (status_d != STAT_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      sum_q       <= 8'd0;
      idx_q       <= 8'd0;
      len_q       <= 8'd0;
      status_q    <= 8'd0;
      pld_valid_q <= 1'b0;
      pld_len_q   <= 8'd0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      status_q    <= status_d;
      pld_valid_q <= pld_valid_d;
      pld_len_q   <= pld_len_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Payload storage; a busy frame never overwrites the held payload.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q[AW-1:0]] <= i_rx_data;
  end

  assign o_pld_data  = (32'(i_pld_addr) < MAX_PAYLOAD) ? buf_q[i_pld_addr] : 8'h00;
  assign o_pld_len   = pld_len_q;
  assign o_pld_valid = pld_valid_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a frame-level model predicts each
// response and payload state; a monitor checks every TX byte as it transfers.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int unsigned MAXP = 8;
  localparam int unsigned TMO  = 40;
  localparam int unsigned AW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic          o_rx_rd_en;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_full;
  logic [AW-1:0] i_pld_addr;
  logic [7:0]    o_pld_data;
  logic [7:0]    o_pld_len;
  logic          o_pld_valid;
  logic          i_pld_ack;
  logic          o_frame_err;

  always #5 clk = ~clk;

  uart_cmd_parser #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYC(TMO), .SOF_BYTE(8'hA5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_rx_rd_en  (o_rx_rd_en),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_full   (i_tx_full),
    .i_pld_addr  (i_pld_addr),
    .o_pld_data  (o_pld_data),
    .o_pld_len   (o_pld_len),
    .o_pld_valid (o_pld_valid),
    .i_pld_ack   (i_pld_ack),
    .o_frame_err (o_frame_err)
  );

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int exp_err  = 0;
  bit pop_pending = 1'b0;
  bit force_full  = 1'b0;
  bit rand_full   = 1'b0;

  // Reference model of what the system side should observe
  bit         mdl_valid = 1'b0;
  logic [7:0] mdl_len   = 8'd0;
  logic [7:0] mdl_buf [256];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // RX FIFO model: first-word-fall-through head, popped when the DUT reads.
  initial begin
    logic [7:0] dropped;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    forever begin
      @(posedge clk);
      if (pop_pending && rx_q.size() > 0) dropped = rx_q.pop_front();
      #1;
      i_rx_valid = (rx_q.size() > 0);
      i_rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  initial begin
    i_tx_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i_tx_full = force_full || (rand_full && ($urandom_range(0, 3) == 0));
    end
  end

  // Monitor: every accepted TX byte is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      pop_pending = o_rx_rd_en && rst_n;
      if (rst_n) begin
        if (o_frame_err) err_cnt++;
        if (o_tx_valid && !i_tx_full) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: got %02h, expected no byte at %0t", o_tx_data, $time);
          end else begin
            check8("tx_byte", o_tx_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  // Queue one frame (possibly truncated) and predict the DUT's reply.
  // keep = number of bytes after SOF actually sent; -1 sends the whole frame.
  task automatic push_frame(input int len, input logic [7:0] pl [256], input logic [7:0] chk,
                            input int keep);
    logic [7:0] full [$];
    logic [7:0] stat;
    int sum;
    int nsend;
    full.push_back(8'(len));
    for (int i = 0; i < len; i++) full.push_back(pl[i]);
    full.push_back(chk);
    nsend = (keep < 0) ? full.size() : keep;
    if (nsend == 0) begin
      stat = STAT_NAK_TIMEOUT;
    end else if (len == 0 || len > int'(MAXP)) begin
      stat  = STAT_NAK_LEN;
      nsend = 1;
    end else if (nsend < len + 2) begin
      stat = STAT_NAK_TIMEOUT;
    end else begin
      sum = len;
      for (int i = 0; i < len; i++) sum += pl[i];
      if (chk != 8'(sum % 256)) stat = STAT_NAK_CHK;
      else if (mdl_valid)       stat = STAT_NAK_BUSY;
      else                      stat = STAT_ACK;
    end
    if (stat == STAT_ACK) begin
      mdl_valid = 1'b1;
      mdl_len   = 8'(len);
      for (int i = 0; i < len; i++) mdl_buf[i] = pl[i];
    end else begin
      exp_err++;
    end
    rx_q.push_back(8'hA5);
    for (int i = 0; i < nsend; i++) rx_q.push_back(full[i]);
    exp_q.push_back(8'hA5);
    exp_q.push_back(stat);
  endtask

  task automatic check_payload();
    check_int("frame_err_count", err_cnt, exp_err);
    check8("pld_valid", 8'(o_pld_valid), 8'(mdl_valid));
    if (mdl_valid) begin
      check8("pld_len", o_pld_len, mdl_len);
      for (int i = 0; i < int'(mdl_len); i++) begin
        i_pld_addr = AW'(i);
        #1;
        check8($sformatf("pld_data[%0d]", i), o_pld_data, mdl_buf[i]);
      end
    end
  endtask

  task automatic wait_resp();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_wait: %0d bytes still pending, expected 0 after %0d cycles", exp_q.size(), cyc);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #2;
    check_payload();
  endtask

  task automatic send_frame(input int len, input logic [7:0] pl [256], input logic [7:0] chk,
                            input int keep);
    push_frame(len, pl, chk, keep);
    wait_resp();
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #2 i_pld_ack = 1'b1;
    @(posedge clk);
    #2 i_pld_ack = 1'b0;
    mdl_valid = 1'b0;
  endtask

  function automatic logic [7:0] good_chk(input int len, input logic [7:0] pl [256]);
    int s = len;
    for (int i = 0; i < len; i++) s += pl[i];
    return 8'(s % 256);
  endfunction

  initial begin
    logic [7:0] pl [256];
    int cyc;
    int sz;
    int len;
    int keep;
    logic [7:0] chk;
    logic [7:0] g;

    rst_n      = 1'b0;
    i_pld_addr = '0;
    i_pld_ack  = 1'b0;
    for (int i = 0; i < 256; i++) pl[i] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check8("rst_rx_rd_en", 8'(o_rx_rd_en), 8'h00);
    check8("rst_tx_valid", 8'(o_tx_valid), 8'h00);
    check8("rst_tx_data", o_tx_data, 8'h00);
    check8("rst_pld_len", o_pld_len, 8'h00);
    check8("rst_pld_valid", 8'(o_pld_valid), 8'h00);
    check8("rst_frame_err", 8'(o_frame_err), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Good frame A5 03 11 22 33 69
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(3, pl, 8'h69, -1);
    check8("good_len_literal", o_pld_len, 8'd3);

    // Bad checksum, zero length, over-length
    pl[0] = 8'h01; pl[1] = 8'h02;
    send_frame(2, pl, 8'h00, -1);
    send_frame(0, pl, 8'h00, -1);
    send_frame(MAXP + 1, pl, 8'h00, -1);
    check_int("len_err_rx_drained", rx_q.size(), 0);

    // Busy (first payload still held), then release and resend
    pl[0] = 8'h7F;
    send_frame(1, pl, 8'h80, -1);
    pulse_ack();
    send_frame(1, pl, 8'h80, -1);
    check8("busy_resend_addr0_literal", o_pld_data, 8'h7F);
    pulse_ack();

    // Timeout mid-payload, then garbage and a good frame
    pl[0] = 8'h44; pl[1] = 8'h10;
    send_frame(2, pl, good_chk(2, pl), 2);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'hFF);
    pl[0] = 8'h5A;
    send_frame(1, pl, good_chk(1, pl), -1);
    pulse_ack();

    // TX backpressure held during RESP0
    force_full = 1'b1;
    pl[0] = 8'hC3; pl[1] = 8'h3C;
    push_frame(2, pl, good_chk(2, pl), -1);
    cyc = 0;
    while (!o_tx_valid && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    check8("bp_resp_reached", 8'(o_tx_valid), 8'h01);
    rx_q.push_back(8'h00);
    repeat (2) @(posedge clk);
    sz = rx_q.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check8("bp_tx_data_held", o_tx_data, 8'hA5);
      check_int("bp_rx_not_popped", rx_q.size(), sz);
    end
    @(posedge clk);
    #1 force_full = 1'b0;
    wait_resp();
    pulse_ack();

    // Randomized frames with random backpressure, acks and corruption
    rand_full = 1'b1;
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        rx_q.push_back(g);
      end
      len = int'($urandom_range(0, MAXP + 1));
      for (int i = 0; i < len; i++) pl[i] = 8'($urandom_range(0, 255));
      chk = good_chk(len, pl);
      if ($urandom_range(0, 3) == 0) chk = 8'(chk ^ 8'($urandom_range(1, 255)));
      keep = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len + 1)) : -1;
      send_frame(len, pl, chk, keep);
      if ($urandom_range(0, 1) == 1) pulse_ack();
    end
    rand_full = 1'b0;

    // Reset in the middle of a frame, then recover
    pulse_ack();
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h03);
    rx_q.push_back(8'h11);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    rx_q.delete();
    mdl_valid = 1'b0;
    @(posedge clk);
    #2;
    check8("midrst_tx_valid", 8'(o_tx_valid), 8'h00);
    check8("midrst_pld_valid", 8'(o_pld_valid), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    pl[0] = 8'h12; pl[1] = 8'h34; pl[2] = 8'h56;
    send_frame(3, pl, good_chk(3, pl), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
